counter_seq: RTL and testbench

COUNTER_SEQ -- requirements
Module: counter_seq

---
 rtl/counter_seq.sv | 157 +++++++++++++++
 tb/tb_counter_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq.sv
// Command sequencer driving an up/down counter.
// Two-entry command FIFO feeding an FSM with registered counter controls.
module counter_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       load,
  output logic [7:0] load_data,
  output logic       enb,
  output logic       mode,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  state_e     state_q;
  logic [7:0] cnt_q;

  logic [9:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] occ_q;
  logic [1:0] occ_d;

  logic       push;
  logic       pop;
  logic [1:0] head_op;
  logic [7:0] head_arg;

  assign cmd_ready = (occ_q < 2'd2);
  assign push      = cmd_valid && cmd_ready && !abort;
  assign pop       = (state_q == S_IDLE) && (occ_q != 2'd0);
  assign head_op   = mem_q[rd_ptr_q][9:8];
  assign head_arg  = mem_q[rd_ptr_q][7:0];
  assign busy      = (occ_q != 2'd0) || (state_q != S_IDLE);

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_arg};
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      load      <= 1'b0;
      load_data <= 8'h00;
      enb       <= 1'b0;
      mode      <= 1'b0;
      done      <= 1'b0;
    end else begin
      load      <= 1'b0;
      load_data <= 8'h00;
      enb       <= 1'b0;
      mode      <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            unique case (head_op)
              OP_LOAD: begin
                state_q   <= S_LOAD;
                load      <= 1'b1;
                enb       <= 1'b1;
                load_data <= head_arg;
              end
              OP_UP, OP_DOWN: begin
                if (head_arg == 8'd0) begin
                  state_q <= S_DONE;
                  done    <= 1'b1;
                end else begin
                  state_q <= S_RUN;
                  cnt_q   <= head_arg - 8'd1;
                  enb     <= 1'b1;
                  mode    <= (head_op == OP_UP);
                end
              end
              OP_HOLD: begin
                if (head_arg == 8'd0) begin
                  state_q <= S_DONE;
                  done    <= 1'b1;
                end else begin
                  state_q <= S_WAIT;
                  cnt_q   <= head_arg - 8'd1;
                end
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
          done    <= 1'b1;
        end
        // cnt_q holds the cycles left after the current one.
        S_RUN: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
            enb   <= 1'b1;
            mode  <= mode;
          end
        end
        S_WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench for counter_seq.
// Expected traces below are worked out by hand from the command timing.
module tb_counter_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_arg = 8'h00;
  logic       load;
  logic [7:0] load_data;
  logic       enb;
  logic       mode;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  int enb_cnt, up_cnt, done_cnt, quiet_cnt;
  logic [9:0] ev_q [$];

  counter_seq dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .load      (load),
    .load_data (load_data),
    .enb       (enb),
    .mode      (mode),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    enb_cnt   = 0;
    up_cnt    = 0;
    done_cnt  = 0;
    quiet_cnt = 0;
    ev_q.delete();
  endtask

  task automatic sample();
    if (enb) enb_cnt++;
    if (enb && mode) up_cnt++;
    if (done) done_cnt++;
    if (busy && !enb && !done) quiet_cnt++;
    if (enb) begin
      if (load) ev_q.push_back({2'b00, load_data});
      else if (mode) ev_q.push_back(10'b01_0000_0000);
      else ev_q.push_back(10'b10_0000_0000);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic drain(input string tag, input int lim);
    int n;
    n = 0;
    while (busy && n < lim) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic push_wait(input logic [1:0] op,
                           input logic [7:0] arg,
                           input int lim,
                           output int stalls);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    stalls    = 0;
    while (!cmd_ready && stalls < lim) begin
      step();
      stalls++;
    end
    step();
    cmd_valid = 1'b0;
  endtask

  logic [11:0] tr_enb, tr_mode, tr_done;
  logic [9:0]  exp_ev [4];
  int          st;

  initial begin
    // Reset
    step();
    step();
    rst = 1'b0;
    chk("rst_load", load, 0);
    chk("rst_ldata", load_data, 8'h00);
    chk("rst_enb", enb, 0);
    chk("rst_mode", mode, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdy", cmd_ready, 1);

    // LOAD 0xAA
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_arg   = 8'hAA;
    step();
    cmd_valid = 1'b0;
    chk("ld_q_busy", busy, 1);
    chk("ld_q_load", load, 0);
    step();
    chk("ld_load", load, 1);
    chk("ld_enb", enb, 1);
    chk("ld_data", load_data, 8'hAA);
    chk("ld_mode", mode, 0);
    step();
    chk("ld_done", done, 1);
    chk("ld_dn_load", load, 0);
    chk("ld_dn_data", load_data, 8'h00);
    chk("ld_dn_enb", enb, 0);
    step();
    chk("ld_end_done", done, 0);
    chk("ld_end_busy", busy, 0);

    // UP 5 then DOWN 3 back-to-back; trace from the pop edge on
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 8'd5;
    step();
    cmd_op  = 2'b10;
    cmd_arg = 8'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tr_enb[11-i]  = enb;
      tr_mode[11-i] = mode;
      tr_done[11-i] = done;
      step();
    end
    chk("ud_enb", tr_enb, 12'b1111_1001_1100);
    chk("ud_mode", tr_mode, 12'b1111_1000_0000);
    chk("ud_done", tr_done, 12'b0000_0100_0010);
    chk("ud_busy", busy, 0);

    // Backpressure while HOLD 10 is waiting
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_arg   = 8'd10;
    step();
    cmd_valid = 1'b0;
    step();
    clr();
    push_wait(2'b01, 8'd2, 50, st);
    chk("bp_a_stall", st, 0);
    push_wait(2'b10, 8'd1, 50, st);
    chk("bp_b_stall", st, 0);
    chk("bp_full_rdy", cmd_ready, 0);
    push_wait(2'b00, 8'h5C, 50, st);
    chk("bp_c_stall", st, 10);
    drain("bp_drain", 100);
    exp_ev[0] = 10'b01_0000_0000;
    exp_ev[1] = 10'b01_0000_0000;
    exp_ev[2] = 10'b10_0000_0000;
    exp_ev[3] = {2'b00, 8'h5C};
    chk("bp_nev", ev_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_ev", (i < ev_q.size()) ? ev_q[i] : 10'h3FF, exp_ev[i]);
    chk("bp_dones", done_cnt, 4);

    // Zero-length UP and HOLD
    clr();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 8'd0;
    step();
    cmd_op = 2'b11;
    step();
    cmd_valid = 1'b0;
    chk("z_done1", done, 1);
    chk("z_enb1", enb, 0);
    drain("z_drain", 20);
    chk("z_enb_cnt", enb_cnt, 0);
    chk("z_dones", done_cnt, 2);

    // Abort on cycle 4 of UP 20 with one command queued
    clr();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 8'd20;
    step();
    cmd_valid = 1'b0;
    step();
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_arg   = 8'd7;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("ab_pre_enb", enb_cnt, 4);
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_arg   = 8'h33;
    step();
    abort     = 1'b0;
    cmd_valid = 1'b0;
    chk("ab_enb", enb, 0);
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    chk("ab_rdy", cmd_ready, 1);
    chk("ab_mode", mode, 0);
    clr();
    for (int i = 0; i < 5; i++) step();
    chk("ab_post_enb", enb_cnt, 0);
    chk("ab_post_done", done_cnt, 0);

    // Reset with abort, mid-RUN of DOWN 9
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_arg   = 8'd9;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("rr_enb_pre", enb, 1);
    rst   = 1'b1;
    abort = 1'b1;
    step();
    rst   = 1'b0;
    abort = 1'b0;
    chk("rr_enb", enb, 0);
    chk("rr_busy", busy, 0);
    chk("rr_rdy", cmd_ready, 1);

    // UP 255
    clr();
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_arg   = 8'd255;
    step();
    cmd_valid = 1'b0;
    drain("u255_drain", 400);
    chk("u255_enb", enb_cnt, 255);
    chk("u255_up", up_cnt, 255);
    chk("u255_done", done_cnt, 1);

    // HOLD 255: one queued cycle plus 255 wait cycles
    clr();
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_arg   = 8'd255;
    step();
    cmd_valid = 1'b0;
    drain("h255_drain", 400);
    chk("h255_quiet", quiet_cnt, 256);
    chk("h255_enb", enb_cnt, 0);
    chk("h255_done", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
